rv32i_wb_stage: RTL and testbench
=================================

Name: rv32i_wb_stage

Overview:
- Parametrised registered writeback stage, sits between memTop and the register interface.
- Completes ALU ops in one cycle. Holds loads until the memory read response arrives, then aligns and sign/zero-extends the load data.
- Drives registered writeback and data-forwarding outputs, a retire pulse/counter, and a sticky load-timeout error.

Parameters:
- XLEN, 32, datapath width; legal values are 32 or 64.
- REG_W, 5, register-address width.
- TIMEOUT, 16, maximum LOAD_WAIT cycles before abort; must be ≥1.
- CNT_W, 32, width of the retire counter.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-low reset.
- valid_in  input  1  memTop presents an instruction.
- ready_out  output  1  stage can accept (valid_in & ready_out = accept).
- pc_in  input  XLEN  instruction PC.
- iw_in  input  32  instruction word; funct3 = iw_in[14:12].
- alu_in  input  XLEN  ALU result; this is the load address for loads.
- wb_en_in  input  1  instruction writes a register.
- wb_reg_in  input  REG_W  destination register.
- is_load_in  input  1  instruction is a load.
- mem_rvalid  input  1  load data valid.
- mem_rdata  input  XLEN  raw aligned memory word/doubleword.
- wb_en_out  output  1  one-cycle register-write strobe.
- wb_reg_out  output  REG_W  writeback register.
- wb_data  output  XLEN  writeback data.
- wb_pc_out  output  XLEN  PC of the retiring instruction.
- df_wb_enable  output  1  forwarding copy of wb_en_out.
- df_wb_reg  output  REG_W  forwarding copy of wb_reg_out.
- df_wb_data  output  XLEN  forwarding copy of wb_data.
- retire  output  1  one-cycle pulse per completed instruction.
- retire_count  output  CNT_W  completed-instruction count; wraps.
- load_timeout_err  output  1  sticky; set when a load aborts on timeout.

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0 except ready_out=1. Timeout counter 0.
- Outputs are registered. df_* always equal wb_en_out / wb_reg_out / wb_data.
- wb_reg_out, wb_data and wb_pc_out hold their last value when no strobe is active.
- IDLE, ready_out=1:
  - Accept of a non-load in cycle N: in cycle N+1, wb_data=alu_in, wb_reg_out=wb_reg_in, wb_pc_out=pc_in, wb_en_out=wb_en_in & (wb_reg_in!=0), retire=1. State stays IDLE, so back-to-back accepts give 1 instr/cycle.
  - Accept of a load: capture pc, reg, wb_en, funct3 and alu_in[2:0]. Go to LOAD_WAIT and clear the timeout counter.
  - No accept: wb_en_out=0, retire=0.
- LOAD_WAIT, ready_out=0:
  - mem_rvalid is sampled only in this state; the earliest response is the cycle after accept.
  - On mem_rvalid in cycle M: formatted data appears on wb_data in cycle M+1 with wb_en_out (x0 suppressed) and retire=1. Return to IDLE.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT: return to IDLE with no writeback and no retire, and set load_timeout_err.
  - If mem_rvalid and timeout expiry coincide, mem_rvalid wins.
- Load formatting (offset = captured alu_in[2:0] for XLEN=64, alu_in[1:0] for XLEN=32):
  - 000 LB: byte at offset, sign-extended.
  - 100 LBU: byte at offset, zero-extended.
  - 001 LH: halfword at offset[..1], sign-extended.
  - 101 LHU: halfword at offset[..1], zero-extended.
  - 010 LW: word; sign-extended to XLEN.
  - 110 LWU: word, zero-extended (XLEN=64 only).
  - 011 LD: full 64 bits (XLEN=64 only).
  - Any other funct3, or a 64-bit-only code when XLEN=32: raw mem_rdata, with wb_en_out still per wb_en_in.
  - Misalignment is not checked; lower offset bits are ignored for wider accesses.
- retire_count increments on every retire pulse and wraps to 0 at 2^CNT_W-1+1.
- load_timeout_err clears only on reset.
- Reset during LOAD_WAIT aborts the pending load: no writeback, no retire.

Test Plan:
- Reset, then three back-to-back non-loads (x5=0x11, x0=0x22, x6=0x33) -> wb_en_out pulses 1,0,1 in cycles N+1..N+3; wb_data 0x11,0x22,0x33; retire_count=3.
- LB, alu_in=0x1003, mem_rdata=0x80FF_1234, rvalid 2 cycles after accept -> ready_out=0 for 2 cycles; wb_data=0xFFFF_FF80, wb_en_out one cycle after rvalid.
- LHU alu_in=0x2002, rdata=0xBEEF_0001 -> wb_data=0x0000_BEEF. Repeat with LH -> wb_data=0xFFFF_BEEF.
- Load with TIMEOUT=4 and no rvalid -> after 4 wait cycles state returns to IDLE, load_timeout_err=1, no wb_en_out, retire_count unchanged. A following non-load completes normally.
- rvalid arriving in the same cycle as timeout expiry -> data written back, load_timeout_err stays 0.
- reset asserted mid-LOAD_WAIT -> outputs immediately 0, ready_out=1; a late rvalid after release is ignored.

Source files
------------

// File: rtl/rv32i_wb_stage.sv
// rtl/rv32i_wb_stage.sv - registered RV32I/RV64I writeback stage with load wait, formatting and retire count
module rv32i_wb_stage #(
    parameter int XLEN    = 32,
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [XLEN-1:0]  pc_in,
    input  logic [31:0]      iw_in,
    input  logic [XLEN-1:0]  alu_in,
    input  logic             wb_en_in,
    input  logic [REG_W-1:0] wb_reg_in,
    input  logic             is_load_in,
    input  logic             mem_rvalid,
    input  logic [XLEN-1:0]  mem_rdata,
    output logic             wb_en_out,
    output logic [REG_W-1:0] wb_reg_out,
    output logic [XLEN-1:0]  wb_data,
    output logic [XLEN-1:0]  wb_pc_out,
    output logic             df_wb_enable,
    output logic [REG_W-1:0] df_wb_reg,
    output logic [XLEN-1:0]  df_wb_data,
    output logic             retire,
    output logic [CNT_W-1:0] retire_count,
    output logic             load_timeout_err
);
    localparam int OFF_W = (XLEN == 64) ? 3 : 2;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t             state_q, state_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [XLEN-1:0]    ld_pc_q, ld_pc_d;
    logic [REG_W-1:0]   ld_reg_q, ld_reg_d;
    logic               ld_en_q, ld_en_d;
    logic [2:0]         ld_f3_q, ld_f3_d;
    logic [OFF_W-1:0]   ld_off_q, ld_off_d;
    logic               wb_en_q, wb_en_d;
    logic [REG_W-1:0]   wb_reg_q, wb_reg_d;
    logic [XLEN-1:0]    wb_data_q, wb_data_d;
    logic [XLEN-1:0]    wb_pc_q, wb_pc_d;
    logic               retire_q, retire_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic [OFF_W-1:0]   hoff, woff;
    logic [XLEN-1:0]    byte_sh, half_sh, word_sh, ld_fmt;

    // Wider accesses ignore the low offset bits, so misaligned loads just drop them.
    assign hoff    = ld_off_q & ~OFF_W'(1);
    assign woff    = ld_off_q & ~OFF_W'(3);
    assign byte_sh = mem_rdata >> {ld_off_q, 3'b000};
    assign half_sh = mem_rdata >> {hoff, 3'b000};
    assign word_sh = mem_rdata >> {woff, 3'b000};

    always_comb begin
        ld_fmt = mem_rdata;
        case (ld_f3_q)
            3'b000: ld_fmt = XLEN'($signed(byte_sh[7:0]));
            3'b100: ld_fmt = XLEN'(byte_sh[7:0]);
            3'b001: ld_fmt = XLEN'($signed(half_sh[15:0]));
            3'b101: ld_fmt = XLEN'(half_sh[15:0]);
            3'b010: ld_fmt = XLEN'($signed(word_sh[31:0]));
            3'b110: ld_fmt = (XLEN == 64) ? XLEN'(word_sh[31:0]) : mem_rdata;
            default: ld_fmt = mem_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        ld_pc_d   = ld_pc_q;
        ld_reg_d  = ld_reg_q;
        ld_en_d   = ld_en_q;
        ld_f3_d   = ld_f3_q;
        ld_off_d  = ld_off_q;
        wb_en_d   = 1'b0;
        wb_reg_d  = wb_reg_q;
        wb_data_d = wb_data_q;
        wb_pc_d   = wb_pc_q;
        retire_d  = 1'b0;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if (is_load_in) begin
                        state_d  = LOAD_WAIT;
                        to_cnt_d = '0;
                        ld_pc_d  = pc_in;
                        ld_reg_d = wb_reg_in;
                        ld_en_d  = wb_en_in & (wb_reg_in != '0);
                        ld_f3_d  = iw_in[14:12];
                        ld_off_d = alu_in[OFF_W-1:0];
                    end else begin
                        wb_en_d   = wb_en_in & (wb_reg_in != '0);
                        wb_reg_d  = wb_reg_in;
                        wb_data_d = alu_in;
                        wb_pc_d   = pc_in;
                        retire_d  = 1'b1;
                    end
                end
            end
            LOAD_WAIT: begin
                if (mem_rvalid) begin
                    state_d   = IDLE;
                    wb_en_d   = ld_en_q;
                    wb_reg_d  = ld_reg_q;
                    wb_data_d = ld_fmt;
                    wb_pc_d   = ld_pc_q;
                    retire_d  = 1'b1;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (to_cnt_d == TO_W'(TIMEOUT)) begin
                        state_d = IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        cnt_d = retire_d ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            to_cnt_q  <= '0;
            ld_pc_q   <= '0;
            ld_reg_q  <= '0;
            ld_en_q   <= 1'b0;
            ld_f3_q   <= '0;
            ld_off_q  <= '0;
            wb_en_q   <= 1'b0;
            wb_reg_q  <= '0;
            wb_data_q <= '0;
            wb_pc_q   <= '0;
            retire_q  <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            to_cnt_q  <= to_cnt_d;
            ld_pc_q   <= ld_pc_d;
            ld_reg_q  <= ld_reg_d;
            ld_en_q   <= ld_en_d;
            ld_f3_q   <= ld_f3_d;
            ld_off_q  <= ld_off_d;
            wb_en_q   <= wb_en_d;
            wb_reg_q  <= wb_reg_d;
            wb_data_q <= wb_data_d;
            wb_pc_q   <= wb_pc_d;
            retire_q  <= retire_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign ready_out        = (state_q == IDLE);
    assign wb_en_out        = wb_en_q;
    assign wb_reg_out       = wb_reg_q;
    assign wb_data          = wb_data_q;
    assign wb_pc_out        = wb_pc_q;
    assign df_wb_enable     = wb_en_q;
    assign df_wb_reg        = wb_reg_q;
    assign df_wb_data       = wb_data_q;
    assign retire           = retire_q;
    assign retire_count     = cnt_q;
    assign load_timeout_err = err_q;
endmodule

// File: tb/tb_rv32i_wb_stage.sv
// tb/tb_rv32i_wb_stage.sv - directed-vector bench for rv32i_wb_stage (XLEN=32, TIMEOUT=4)
module tb_rv32i_wb_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] pc_in;
    logic [31:0] iw_in;
    logic [31:0] alu_in;
    logic        wb_en_in;
    logic [4:0]  wb_reg_in;
    logic        is_load_in;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wb_en_out;
    logic [4:0]  wb_reg_out;
    logic [31:0] wb_data;
    logic [31:0] wb_pc_out;
    logic        df_wb_enable;
    logic [4:0]  df_wb_reg;
    logic [31:0] df_wb_data;
    logic        retire;
    logic [31:0] retire_count;
    logic        load_timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cnt = 0;

    rv32i_wb_stage #(.XLEN(32), .REG_W(5), .TIMEOUT(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
        .pc_in(pc_in), .iw_in(iw_in), .alu_in(alu_in), .wb_en_in(wb_en_in),
        .wb_reg_in(wb_reg_in), .is_load_in(is_load_in), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .wb_en_out(wb_en_out), .wb_reg_out(wb_reg_out),
        .wb_data(wb_data), .wb_pc_out(wb_pc_out), .df_wb_enable(df_wb_enable),
        .df_wb_reg(df_wb_reg), .df_wb_data(df_wb_data), .retire(retire),
        .retire_count(retire_count), .load_timeout_err(load_timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb(input string tag, input logic en, input logic [4:0] rd,
                            input logic [31:0] data, input logic [31:0] pc, input logic ret);
        check({tag, ".en"},     32'(wb_en_out), 32'(en));
        check({tag, ".reg"},    32'(wb_reg_out), 32'(rd));
        check({tag, ".data"},   wb_data, data);
        check({tag, ".pc"},     wb_pc_out, pc);
        check({tag, ".retire"}, 32'(retire), 32'(ret));
        check({tag, ".df_en"},  32'(df_wb_enable), 32'(en));
        check({tag, ".df_reg"}, 32'(df_wb_reg), 32'(rd));
        check({tag, ".df_data"}, df_wb_data, data);
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0; is_load_in = 1'b0; wb_en_in = 1'b0; mem_rvalid = 1'b0;
    endtask

    task automatic nonload(input string tag, input logic [4:0] rd, input logic [31:0] data,
                           input logic [31:0] pc);
        valid_in = 1'b1; is_load_in = 1'b0; wb_en_in = 1'b1;
        wb_reg_in = rd; alu_in = data; pc_in = pc; iw_in = 32'h0000_0033;
        tick();
        exp_cnt++;
        check_wb(tag, rd != 5'd0, rd, data, pc, 1'b1);
    endtask

    // Accept a load, answer it after 'delay' wait cycles, then check the formatted writeback.
    task automatic load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [4:0] rd, input logic [31:0] rdata, input int delay,
                        input logic [31:0] exp_data, input logic [31:0] pc);
        valid_in = 1'b1; is_load_in = 1'b1; wb_en_in = 1'b1;
        wb_reg_in = rd; alu_in = addr; pc_in = pc; iw_in = {17'd0, f3, 12'h003};
        mem_rdata = rdata;
        tick();
        idle_inputs();
        for (int i = 1; i <= delay; i++) begin
            check({tag, ".busy"}, 32'(ready_out), 32'd0);
            mem_rvalid = (i == delay);
            tick();
        end
        mem_rvalid = 1'b0;
        exp_cnt++;
        check_wb(tag, rd != 5'd0, rd, exp_data, pc, 1'b1);
        check({tag, ".cnt"}, retire_count, 32'(exp_cnt));
        check({tag, ".ready"}, 32'(ready_out), 32'd1);
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        pc_in = '0; iw_in = '0; alu_in = '0; wb_reg_in = '0; mem_rdata = '0;
        tick(); tick();
        check("rst.ready", 32'(ready_out), 32'd1);
        check_wb("rst", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        check("rst.cnt", retire_count, 32'd0);
        check("rst.err", 32'(load_timeout_err), 32'd0);
        reset = 1'b1;
        tick();

        nonload("nl0", 5'd5, 32'h11, 32'h100);
        nonload("nl1", 5'd0, 32'h22, 32'h104);
        nonload("nl2", 5'd6, 32'h33, 32'h108);
        idle_inputs();
        tick();
        check_wb("hold", 1'b0, 5'd6, 32'h33, 32'h108, 1'b0);
        check("nl.cnt", retire_count, 32'd3);

        load("lb",  3'b000, 32'h1003, 5'd7,  32'h80FF_1234, 2, 32'hFFFF_FF80, 32'h200);
        load("lhu", 3'b101, 32'h2002, 5'd8,  32'hBEEF_0001, 1, 32'h0000_BEEF, 32'h204);
        load("lh",  3'b001, 32'h2002, 5'd9,  32'hBEEF_0001, 1, 32'hFFFF_BEEF, 32'h208);
        load("lbu", 3'b100, 32'h3001, 5'd10, 32'h80FF_1234, 3, 32'h0000_0012, 32'h20C);
        load("lw",  3'b010, 32'h4002, 5'd11, 32'hCAFE_F00D, 1, 32'hCAFE_F00D, 32'h210);
        load("ld32", 3'b011, 32'h5000, 5'd12, 32'h1234_5678, 1, 32'h1234_5678, 32'h214);
        load("lbx0", 3'b000, 32'h6000, 5'd0, 32'h0000_007F, 1, 32'h0000_007F, 32'h218);
        // Response lands in the final wait cycle: data must win over the timeout.
        load("edge", 3'b010, 32'h7000, 5'd13, 32'h5555_AAAA, 4, 32'h5555_AAAA, 32'h21C);
        check("edge.err", 32'(load_timeout_err), 32'd0);

        valid_in = 1'b1; is_load_in = 1'b1; wb_en_in = 1'b1;
        wb_reg_in = 5'd14; alu_in = 32'h8000; pc_in = 32'h220; iw_in = 32'h0000_2003;
        tick();
        idle_inputs();
        for (int i = 1; i <= 4; i++) begin
            check("to.busy", 32'(ready_out), 32'd0);
            check("to.en", 32'(wb_en_out), 32'd0);
            tick();
        end
        check("to.ready", 32'(ready_out), 32'd1);
        check("to.err", 32'(load_timeout_err), 32'd1);
        check_wb("to", 1'b0, 5'd13, 32'h5555_AAAA, 32'h21C, 1'b0);
        check("to.cnt", retire_count, 32'(exp_cnt));
        nonload("after_to", 5'd15, 32'h99, 32'h224);
        idle_inputs();
        tick();
        check("after_to.cnt", retire_count, 32'(exp_cnt));
        check("after_to.err", 32'(load_timeout_err), 32'd1);

        valid_in = 1'b1; is_load_in = 1'b1; wb_en_in = 1'b1;
        wb_reg_in = 5'd16; alu_in = 32'h9000; pc_in = 32'h228; iw_in = 32'h0000_2003;
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        idle_inputs();
        tick();
        reset = 1'b0;
        #1;
        check("mid.ready", 32'(ready_out), 32'd1);
        check_wb("mid", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        check("mid.cnt", retire_count, 32'd0);
        check("mid.err", 32'(load_timeout_err), 32'd0);
        tick();
        reset = 1'b1;
        tick();
        mem_rvalid = 1'b1;
        tick();
        mem_rvalid = 1'b0;
        check_wb("late", 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        check("late.cnt", retire_count, 32'd0);
        check("late.ready", 32'(ready_out), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
